// File: rtl/dat_mem_pkg.sv
// ============================================================================
// Module   : dat_mem_pkg
// Purpose  : Shared widths and types for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dat_mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef logic port_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter with combinational grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import dat_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_id_t   prio
);

  // Grants are suppressed during reset so no access can leak into memory.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        gnt = prio ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Priority moves to the port that was not served; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (gnt[0]) begin
      prio <= 1'b1;
    end else if (gnt[1]) begin
      prio <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dat_mem_arbiter.sv
// ============================================================================
// Module   : dat_mem_arbiter
// Purpose  : Shares a single-port data memory between core and loader ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dat_mem_arbiter #(
  parameter int DATA_W = dat_mem_pkg::DATA_W,
  parameter int ADDR_W = dat_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_writeEnable,
  input  logic [DATA_W-1:0] mem_dataOut
);

  import dat_mem_pkg::*;

  logic [1:0] w_gnt;
  port_id_t   w_prio;
  mem_req_t   w_req0;
  mem_req_t   w_req1;
  mem_req_t   w_sel;
  logic       w_rd0;
  logic       w_rd1;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .gnt   (w_gnt),
    .prio  (w_prio)
  );

  assign gnt0 = w_gnt[0];
  assign gnt1 = w_gnt[1];

  assign w_req0 = '{we: we0, addr: addr0, wdata: wdata0};
  assign w_req1 = '{we: we1, addr: addr1, wdata: wdata1};

  // Port 0 drives the bus whenever port 1 is not granted, including idle.
  assign w_sel           = gnt1 ? w_req1 : w_req0;
  assign mem_addr        = w_sel.addr;
  assign mem_dataIn      = w_sel.wdata;
  assign mem_writeEnable = w_sel.we & (gnt0 | gnt1);

  assign w_rd0 = gnt0 & ~we0;
  assign w_rd1 = gnt1 & ~we1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= w_rd0;
      rvalid1 <= w_rd1;
      if (w_rd0) begin
        rdata0 <= mem_dataOut;
      end
      if (w_rd1) begin
        rdata1 <= mem_dataOut;
      end
    end
  end

endmodule

`default_nettype wire
